spi_byte_rx: RTL and testbench
==============================

SPI_BYTE_RX -- requirements
Module: spi_byte_rx

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1: 1 = first received bit lands in bit 7, 0 = first received bit lands in bit 0.
REQ-002 SHALL have parameter IDX_W, default 16: width of the byte index counter.
REQ-003 SHALL have port clk_i, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port spi_mosi_i, input, 1: MOSI level, already synchronized to clk_i.
REQ-006 SHALL have port spi_cs_n_i, input, 1: CS_n level, already synchronized.
REQ-007 SHALL have port sclk_pos_edge_i, input, 1: one-cycle SCLK rising-edge enable from the edge detector.
REQ-008 SHALL have port cs_n_neg_edge_i, input, 1: one-cycle CS_n falling-edge enable (frame start).
REQ-009 SHALL have port cs_n_pos_edge_i, input, 1: one-cycle CS_n rising-edge enable (frame end).
REQ-010 SHALL have port byte_vld_o, output, 1: one-cycle pulse, byte_data_o/byte_idx_o valid.
REQ-011 SHALL have port byte_data_o, output, 8: last completed byte, held until next byte_vld_o.
REQ-012 SHALL have port byte_idx_o, output, IDX_W: zero-based position of byte_data_o within the frame.
REQ-013 SHALL have ports frame_start_o, frame_end_o, frame_err_o, output, 1 each: one-cycle pulses.

Function
REQ-014 SHALL implement states IDLE and RECV; reset state IDLE.
REQ-015 IDLE: on cs_n_neg_edge_i -> RECV, bit counter := 0, byte index := 0, shift register := 0; frame_start_o pulses the next cycle.
REQ-016 IDLE: sclk_pos_edge_i and cs_n_pos_edge_i SHALL be ignored (no outputs).
REQ-017 RECV: on sclk_pos_edge_i with spi_cs_n_i low, SHALL shift in spi_mosi_i (left-shift if MSB_FIRST, else right-shift) and increment the 3-bit bit counter modulo 8.
REQ-018 On the eighth bit (counter 7 -> 0), byte_vld_o SHALL pulse exactly one cycle after the enable cycle, with byte_data_o = assembled byte including that bit.
REQ-019 byte_idx_o SHALL equal the index of the byte just presented; the internal index SHALL then increment, saturating at 2^IDX_W-1 (no wrap).
REQ-020 RECV: on cs_n_pos_edge_i -> IDLE; frame_end_o pulses next cycle; frame_err_o pulses in the same cycle iff bit counter != 0 (partial byte discarded, no byte_vld_o).
REQ-021 Simultaneous sclk_pos_edge_i and cs_n_pos_edge_i SHALL accept the bit first, then end the frame; if that bit completes a byte, byte_vld_o and frame_end_o pulse in the same cycle with frame_err_o low.
REQ-022 cs_n_neg_edge_i while in RECV SHALL restart the frame as in REQ-015 (partial byte dropped, frame_err_o pulses, frame_start_o pulses).
REQ-023 All outputs SHALL be registered; latency from any input enable to its output pulse is exactly 1 clk_i cycle.
REQ-024 Back-to-back sclk_pos_edge_i on consecutive cycles SHALL each be accepted.

Reset
REQ-025 While rst_n_i low: state IDLE, counters 0, shift register 0, byte_data_o = 8'h00, byte_idx_o = 0, all pulse outputs 0.
REQ-026 Reset asserted mid-frame SHALL drop the frame silently (no frame_end_o/frame_err_o after release).

Structure
REQ-027 The state enum (IDLE, RECV) SHALL live in shared package spi_pkg; no other typedefs required.
REQ-028 SHALL be a single module with no sub-modules; edge2en instances for SCLK and CS_n reside in the parent.

Verification
REQ-029 CS_n fall, 8 SCLK edges MOSI=1,0,1,0,0,1,0,1, CS_n rise -> frame_start_o, byte_vld_o with byte_data_o=8'hA5 idx 0, frame_end_o, frame_err_o=0.
REQ-030 Same bits with MSB_FIRST=0 -> byte_data_o=8'hA5 bit-reversed = 8'hA5 (palindrome) and then 8'h3C stream 00111100 -> 8'h3C.
REQ-031 24 bits 0xFF,0x00,0x81 in one frame -> three byte_vld_o, idx 0,1,2, data FF,00,81.
REQ-032 5 SCLK edges then CS_n rise -> no byte_vld_o, frame_end_o and frame_err_o pulse together.
REQ-033 8th SCLK edge coincident with cs_n_pos_edge_i -> byte_vld_o, frame_end_o same cycle, frame_err_o=0.
REQ-034 rst_n_i low after 3 bits, released, SCLK edges without CS_n fall -> all outputs stay 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI byte receiver.
//   spi_state_e : receiver FSM states (IDLE = waiting for CS_n fall, RECV = frame open)
package spi_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } spi_state_e;

endpackage : spi_pkg

// File: rtl/spi_byte_rx.sv
// SPI byte receiver: assembles MOSI bits sampled on SCLK rising-edge enables
// into bytes, tagging each with its zero-based position in the CS_n frame.
// Ports:
//   clk_i, rst_n_i            : system clock, async active-low reset
//   spi_mosi_i, spi_cs_n_i    : synchronized MOSI / CS_n levels
//   sclk_pos_edge_i           : SCLK rising-edge enable (one cycle)
//   cs_n_neg_edge_i           : CS_n falling-edge enable (frame start)
//   cs_n_pos_edge_i           : CS_n rising-edge enable (frame end)
//   byte_vld_o                : one-cycle pulse, byte_data_o/byte_idx_o valid
//   byte_data_o, byte_idx_o   : last completed byte and its frame index (held)
//   frame_start_o/_end_o/_err_o : one-cycle frame event pulses
module spi_byte_rx
  import spi_pkg::*;
#(
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned IDX_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             spi_mosi_i,
  input  logic             spi_cs_n_i,
  input  logic             sclk_pos_edge_i,
  input  logic             cs_n_neg_edge_i,
  input  logic             cs_n_pos_edge_i,
  output logic             byte_vld_o,
  output logic [7:0]       byte_data_o,
  output logic [IDX_W-1:0] byte_idx_o,
  output logic             frame_start_o,
  output logic             frame_end_o,
  output logic             frame_err_o
);

  localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};

  spi_state_e       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       data_d;
  logic [IDX_W-1:0] idx_out_d;
  logic             vld_d, start_d, end_d, err_d;

  logic             take_bit;
  logic [2:0]       cnt_after;
  logic [7:0]       shift_in;

  // A bit coinciding with the CS_n rising enable is still part of the frame,
  // even though the synchronized CS_n level may already read high.
  assign take_bit  = (state_q == RECV) && !cs_n_neg_edge_i && sclk_pos_edge_i &&
                     (!spi_cs_n_i || cs_n_pos_edge_i);
  assign cnt_after = take_bit ? bit_cnt_q + 3'd1 : bit_cnt_q;
  assign shift_in  = MSB_FIRST ? {shift_q[6:0], spi_mosi_i} : {spi_mosi_i, shift_q[7:1]};

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a CS_n fall always (re)opens a frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cs_n_neg_edge_i) state_d = RECV;
      RECV: begin
        if (cs_n_neg_edge_i)      state_d = RECV;
        else if (cs_n_pos_edge_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    data_d    = byte_data_o;
    idx_out_d = byte_idx_o;
    vld_d     = 1'b0;
    start_d   = 1'b0;
    end_d     = 1'b0;
    err_d     = 1'b0;
    if (cs_n_neg_edge_i) begin
      // Restart drops any partial byte of an open frame
      start_d   = 1'b1;
      err_d     = (state_q == RECV) && (bit_cnt_q != 3'd0);
      bit_cnt_d = 3'd0;
      shift_d   = 8'h00;
      idx_d     = '0;
    end else if (state_q == RECV) begin
      if (take_bit) begin
        shift_d   = shift_in;
        bit_cnt_d = cnt_after;
        if (bit_cnt_q == 3'd7) begin
          vld_d     = 1'b1;
          data_d    = shift_in;
          idx_out_d = idx_q;
          idx_d     = (idx_q == IDX_MAX) ? idx_q : idx_q + IDX_W'(1);
        end
      end
      if (cs_n_pos_edge_i) begin
        end_d     = 1'b1;
        err_d     = (cnt_after != 3'd0);
        bit_cnt_d = 3'd0;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      idx_q         <= '0;
      byte_vld_o    <= 1'b0;
      byte_data_o   <= 8'h00;
      byte_idx_o    <= '0;
      frame_start_o <= 1'b0;
      frame_end_o   <= 1'b0;
      frame_err_o   <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      idx_q         <= idx_d;
      byte_vld_o    <= vld_d;
      byte_data_o   <= data_d;
      byte_idx_o    <= idx_out_d;
      frame_start_o <= start_d;
      frame_end_o   <= end_d;
      frame_err_o   <= err_d;
    end
  end

endmodule : spi_byte_rx

// File: tb/tb_spi_byte_rx.sv
// Self-checking bench for spi_byte_rx: two instances share one stimulus stream,
// one MSB-first with a 16-bit index and one LSB-first with a 2-bit index (to
// reach index saturation), both checked every cycle against a frame-level model.
module tb_spi_byte_rx;

  logic clk = 1'b0;
  logic rst_n;
  logic mosi, cs_n, sclk_pe, cs_fall, cs_rise;

  logic        a_vld, a_start, a_end, a_err;
  logic [7:0]  a_data;
  logic [15:0] a_idx;
  logic        b_vld, b_start, b_end, b_err;
  logic [7:0]  b_data;
  logic [1:0]  b_idx;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state (frame level)
  bit       in_frame;
  int       nbits;
  bit       bitsv[8];
  int       nbytes;
  bit       e_vld, e_start, e_end, e_err;
  bit [7:0] e_data_a, e_data_b;
  int       e_idx_a, e_idx_b;

  always #5 clk = ~clk;

  spi_byte_rx #(.MSB_FIRST(1'b1), .IDX_W(16)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .spi_mosi_i(mosi), .spi_cs_n_i(cs_n),
    .sclk_pos_edge_i(sclk_pe), .cs_n_neg_edge_i(cs_fall), .cs_n_pos_edge_i(cs_rise),
    .byte_vld_o(a_vld), .byte_data_o(a_data), .byte_idx_o(a_idx),
    .frame_start_o(a_start), .frame_end_o(a_end), .frame_err_o(a_err));

  spi_byte_rx #(.MSB_FIRST(1'b0), .IDX_W(2)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .spi_mosi_i(mosi), .spi_cs_n_i(cs_n),
    .sclk_pos_edge_i(sclk_pe), .cs_n_neg_edge_i(cs_fall), .cs_n_pos_edge_i(cs_rise),
    .byte_vld_o(b_vld), .byte_data_o(b_data), .byte_idx_o(b_idx),
    .frame_start_o(b_start), .frame_end_o(b_end), .frame_err_o(b_err));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a_vld", 32'(a_vld), 32'(e_vld));     chk("b_vld", 32'(b_vld), 32'(e_vld));
    chk("a_start", 32'(a_start), 32'(e_start)); chk("b_start", 32'(b_start), 32'(e_start));
    chk("a_end", 32'(a_end), 32'(e_end));     chk("b_end", 32'(b_end), 32'(e_end));
    chk("a_err", 32'(a_err), 32'(e_err));     chk("b_err", 32'(b_err), 32'(e_err));
    chk("a_data", 32'(a_data), 32'(e_data_a)); chk("b_data", 32'(b_data), 32'(e_data_b));
    chk("a_idx", 32'(a_idx), 32'(e_idx_a));   chk("b_idx", 32'(b_idx), 32'(e_idx_b));
  endtask

  // Model one clock of input enables; expected pulses appear after the edge.
  task automatic model(input bit s, input bit m, input bit f, input bit r);
    int v_a, v_b;
    e_vld = 0; e_start = 0; e_end = 0; e_err = 0;
    if (f) begin
      e_start = 1;
      e_err   = in_frame && (nbits != 0);
      in_frame = 1; nbits = 0; nbytes = 0;
    end else if (in_frame) begin
      if (s) begin
        bitsv[nbits] = m;
        nbits++;
        if (nbits == 8) begin
          v_a = 0; v_b = 0;
          for (int i = 0; i < 8; i++) begin
            v_a += int'(bitsv[i]) * (1 << (7 - i));
            v_b += int'(bitsv[i]) * (1 << i);
          end
          e_vld = 1;
          e_data_a = 8'(v_a);
          e_data_b = 8'(v_b);
          e_idx_a  = nbytes;
          e_idx_b  = (nbytes > 3) ? 3 : nbytes;
          nbytes++;
          nbits = 0;
        end
      end
      if (r) begin
        e_end = 1;
        e_err = (nbits != 0);
        in_frame = 0;
        nbits = 0;
      end
    end
  endtask

  task automatic model_reset();
    in_frame = 0; nbits = 0; nbytes = 0;
    e_vld = 0; e_start = 0; e_end = 0; e_err = 0;
    e_data_a = 8'h00; e_data_b = 8'h00; e_idx_a = 0; e_idx_b = 0;
  endtask

  // Drive one cycle of inputs (called #1 after a rising edge), then check.
  task automatic step(input bit s, input bit m, input bit f, input bit r);
    sclk_pe = s; mosi = m; cs_fall = f; cs_rise = r;
    if (f) cs_n = 1'b0;
    if (r) cs_n = 1'b1;
    model(s, m, f, r);
    @(posedge clk); #1;
    check_all();
    sclk_pe = 0; cs_fall = 0; cs_rise = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  // Send n bits of w, MSB of the n-bit field first on the wire.
  task automatic send_bits(input logic [31:0] w, input int n, input bit end_on_last);
    logic [31:0] t;
    t = w;
    for (int i = n - 1; i >= 0; i--)
      step(1, t[i], 0, (i == 0) && end_on_last);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 0; sclk_pe = 0; cs_fall = 0; cs_rise = 0; mosi = 0;
    model_reset();
    #1;
    check_all();
    repeat (cycles) @(posedge clk);
    #1;
    check_all();
    rst_n = 1;
  endtask

  initial begin
    cs_n = 1; mosi = 0; sclk_pe = 0; cs_fall = 0; cs_rise = 0; rst_n = 1;
    @(posedge clk); #1;
    do_reset(3);
    idle(2);

    // Single byte 1,0,1,0,0,1,0,1 -> A5 in both bit orders
    step(0, 0, 1, 0);
    send_bits(32'hA5, 8, 0);
    chk("a5_msb", 32'(a_data), 32'hA5);
    chk("a5_lsb", 32'(b_data), 32'hA5);
    step(0, 0, 0, 1);
    idle(2);

    // Stream 00111100 -> 3C either way
    step(0, 0, 1, 0);
    send_bits(32'h3C, 8, 0);
    chk("3c_lsb", 32'(b_data), 32'h3C);
    step(0, 0, 0, 1);
    idle(1);

    // Three bytes, back-to-back edges; then 5-byte frame for index saturation
    step(0, 0, 1, 0);
    send_bits(32'hFF0081, 24, 0);
    chk("idx2_a", 32'(a_idx), 32'd2);
    chk("data81", 32'(a_data), 32'h81);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    send_bits(32'h12345678, 32, 0);
    send_bits(32'h9A, 8, 0);
    chk("idx_sat_b", 32'(b_idx), 32'd3);
    step(0, 0, 0, 1);
    idle(1);

    // Partial byte (5 bits) then CS_n rise -> end + err, no byte
    step(0, 0, 1, 0);
    send_bits(32'h15, 5, 0);
    step(0, 0, 0, 1);
    chk("part_err", 32'(a_err), 32'd1);
    idle(1);

    // 8th edge coincident with CS_n rise
    step(0, 0, 1, 0);
    send_bits(32'hC3, 8, 1);
    chk("coinc_vld", 32'(a_vld), 32'd1);
    idle(1);

    // Restart mid-byte
    step(0, 0, 1, 0);
    send_bits(32'h3, 3, 0);
    step(0, 0, 1, 0);
    send_bits(32'h5A, 8, 0);
    step(0, 0, 0, 1);

    // Reset after 3 bits, then SCLK edges with no CS_n fall
    step(0, 0, 1, 0);
    send_bits(32'h5, 3, 0);
    @(negedge clk);
    do_reset(2);
    @(posedge clk); #1;
    check_all();
    cs_n = 0;
    send_bits(32'hFF, 8, 0);
    step(0, 0, 0, 1);
    idle(2);

    // Randomized frames
    for (int fr = 0; fr < 60; fr++) begin
      int gap, nb, ex, total;
      bit coinc;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++)
        step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0,
             bit'($urandom_range(0, 4) == 0));
      step(0, 0, 1, 0);
      nb = $urandom_range(0, 5);
      ex = $urandom_range(0, 7);
      total = nb * 8 + ex;
      coinc = (total > 0) && ($urandom_range(0, 2) == 0);
      for (int i = 0; i < total; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        step(1, bit'($urandom_range(0, 1)), 0, coinc && (i == total - 1));
      end
      if (ex > 0 && !coinc && $urandom_range(0, 4) == 0) begin
        step(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(1, bit'($urandom_range(0, 1)), 0, 0);
      end
      if (!coinc) step(0, 0, 0, 1);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_spi_byte_rx
